// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-lite controller: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with memory-ready handshake, illegal-opcode trap and a retired-instruction counter.
module mc_control_fsm #(
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       in,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdest,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [RET_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_NORI = 6'b001111;

  state_t           state_q, state_d;
  logic [RET_W-1:0] retired_q, retired_d;

  logic       pcwrite_s, pcwritecond_s, iord_s, memread_s, memwrite_s, irwrite_s;
  logic       memtoreg_s, regdest_s, regwrite_s, alusrca_s, illegal_s, done_s;
  logic [1:0] alusrcb_s, aluop_s, pcsource_s;

  // State and retired-count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= {RET_W{1'b0}};
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic; the unused codes 12-15 fall through to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (in)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_NORI:      state_d = S_IEXEC;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (in == OP_SW) state_d = S_MEMWR;
        else             state_d = S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
        else           state_d = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready) state_d = S_FETCH;
        else           state_d = S_MEMWR;
      end
      S_EXEC:  state_d = S_RWB;
      S_IEXEC: state_d = S_IWB;
      S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_TRAP: state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Moore output decode; FETCH gates its IR/PC loads and MEMWR its retire on mem_ready
  always_comb begin
    pcwrite_s     = 1'b0;
    pcwritecond_s = 1'b0;
    iord_s        = 1'b0;
    memread_s     = 1'b0;
    memwrite_s    = 1'b0;
    irwrite_s     = 1'b0;
    memtoreg_s    = 1'b0;
    regdest_s     = 1'b0;
    regwrite_s    = 1'b0;
    alusrca_s     = 1'b0;
    alusrcb_s     = 2'b00;
    aluop_s       = 2'b00;
    pcsource_s    = 2'b00;
    illegal_s     = 1'b0;
    done_s        = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread_s = 1'b1;
        alusrcb_s = 2'b01;
        irwrite_s = mem_ready;
        pcwrite_s = mem_ready;
      end
      S_DECODE: alusrcb_s = 2'b11;
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      S_MEMRD: begin
        memread_s = 1'b1;
        iord_s    = 1'b1;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
        done_s     = 1'b1;
      end
      S_MEMWR: begin
        memwrite_s = 1'b1;
        iord_s     = 1'b1;
        done_s     = mem_ready;
      end
      S_EXEC: begin
        alusrca_s = 1'b1;
        aluop_s   = 2'b10;
      end
      S_RWB: begin
        regwrite_s = 1'b1;
        regdest_s  = 1'b1;
        done_s     = 1'b1;
      end
      S_BRANCH: begin
        alusrca_s     = 1'b1;
        aluop_s       = 2'b01;
        pcwritecond_s = 1'b1;
        pcsource_s    = 2'b01;
        done_s        = 1'b1;
      end
      S_IEXEC: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        aluop_s   = 2'b11;
      end
      S_IWB: begin
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      S_TRAP: illegal_s = 1'b1;
      default: begin
        illegal_s = 1'b0;
      end
    endcase
  end

  // Retire counter next value, wraps naturally at all-ones
  always_comb begin
    if (done_s) retired_d = retired_q + {{(RET_W-1){1'b0}}, 1'b1};
    else        retired_d = retired_q;
  end

  // Reset forces every strobe and mux select low so no write escapes mid-instruction
  always_comb begin
    if (reset) begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdest     = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      aluop       = 2'b00;
      pcsource    = 2'b00;
      illegal_op  = 1'b0;
      instr_done  = 1'b0;
    end else begin
      pcwrite     = pcwrite_s;
      pcwritecond = pcwritecond_s;
      iord        = iord_s;
      memread     = memread_s;
      memwrite    = memwrite_s;
      irwrite     = irwrite_s;
      memtoreg    = memtoreg_s;
      regdest     = regdest_s;
      regwrite    = regwrite_s;
      alusrca     = alusrca_s;
      alusrcb     = alusrcb_s;
      aluop       = aluop_s;
      pcsource    = pcsource_s;
      illegal_op  = illegal_s;
      instr_done  = done_s;
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a driver queues the expected state/controls/count per
// cycle from directed instruction sequences; a monitor pops and compares mid-cycle.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdest;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      c;
    logic [3:0] ret;
  } exp_t;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] NORI = 6'b001111;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] in = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdest, regwrite, alusrca, illegal_op, instr_done;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] retired, state;

  exp_t       q[$];
  logic [3:0] ret_m = 4'd0;
  int         checks = 0;
  int         errors = 0;
  int         cyc_n  = 0;

  mc_control_fsm #(.RET_W(4)) dut (
    .clk(clk), .reset(reset), .in(in), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdest(regdest),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .illegal_op(illegal_op), .instr_done(instr_done),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  // Hand-written control word per state
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr, input logic rs);
    ctrl_t c;
    c = '0;
    if (!rs) begin
      case (st)
        4'd0:  begin c.memread = 1'b1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
        4'd1:  c.alusrcb = 2'b11;
        4'd2:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
        4'd3:  begin c.memread = 1'b1; c.iord = 1'b1; end
        4'd4:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.instr_done = 1'b1; end
        4'd5:  begin c.memwrite = 1'b1; c.iord = 1'b1; c.instr_done = mr; end
        4'd6:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
        4'd7:  begin c.regwrite = 1'b1; c.regdest = 1'b1; c.instr_done = 1'b1; end
        4'd8:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1;
                     c.pcsource = 2'b01; c.instr_done = 1'b1; end
        4'd9:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 2'b11; end
        4'd10: begin c.regwrite = 1'b1; c.instr_done = 1'b1; end
        4'd11: c.illegal_op = 1'b1;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  task automatic cyc(input logic [5:0] op, input logic mr, input logic rs, input logic [3:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    in = op;
    mem_ready = mr;
    reset = rs;
    if (rs) ret_m = 4'd0;
    e.st  = st;
    e.c   = exp_ctrl(st, mr, rs);
    e.ret = ret_m;
    q.push_back(e);
    if (e.c.instr_done) ret_m = ret_m + 4'd1;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation
  always @(negedge clk) begin
    exp_t  e;
    ctrl_t got;
    if (q.size() > 0) begin
      e = q.pop_front();
      cyc_n = cyc_n + 1;
      got = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdest,
             regwrite, alusrca, alusrcb, aluop, pcsource, illegal_op, instr_done};
      checks = checks + 1;
      if (state !== e.st) begin
        errors = errors + 1;
        $display("FAIL state cyc %0d: got %0d expected %0d", cyc_n, state, e.st);
      end
      checks = checks + 1;
      if (got !== e.c) begin
        errors = errors + 1;
        $display("FAIL ctrl cyc %0d: got %05h expected %05h", cyc_n, got, e.c);
      end
      checks = checks + 1;
      if (retired !== e.ret) begin
        errors = errors + 1;
        $display("FAIL retired cyc %0d: got %0d expected %0d", cyc_n, retired, e.ret);
      end
    end
  end

  initial begin
    cyc(R, 1'b1, 1'b1, 4'd0);
    cyc(R, 1'b1, 1'b1, 4'd0);
    // R-format, zero wait
    cyc(R, 1'b1, 1'b0, 4'd0); cyc(R, 1'b1, 1'b0, 4'd1);
    cyc(R, 1'b1, 1'b0, 4'd6); cyc(R, 1'b1, 1'b0, 4'd7);
    // lw: two FETCH waits, one MEMRD wait
    cyc(LW, 1'b0, 1'b0, 4'd0); cyc(LW, 1'b0, 1'b0, 4'd0); cyc(LW, 1'b1, 1'b0, 4'd0);
    cyc(LW, 1'b1, 1'b0, 4'd1); cyc(LW, 1'b1, 1'b0, 4'd2); cyc(LW, 1'b0, 1'b0, 4'd3);
    cyc(LW, 1'b1, 1'b0, 4'd3); cyc(LW, 1'b1, 1'b0, 4'd4);
    // sw then beq
    cyc(SW, 1'b1, 1'b0, 4'd0); cyc(SW, 1'b1, 1'b0, 4'd1);
    cyc(SW, 1'b1, 1'b0, 4'd2); cyc(SW, 1'b1, 1'b0, 4'd5);
    cyc(BEQ, 1'b1, 1'b0, 4'd0); cyc(BEQ, 1'b0, 1'b0, 4'd1); cyc(BEQ, 1'b0, 1'b0, 4'd8);
    // nori
    cyc(NORI, 1'b1, 1'b0, 4'd0); cyc(NORI, 1'b1, 1'b0, 4'd1);
    cyc(NORI, 1'b0, 1'b0, 4'd9); cyc(NORI, 1'b1, 1'b0, 4'd10);
    // illegal opcode traps without retiring
    cyc(BAD, 1'b1, 1'b0, 4'd0); cyc(BAD, 1'b1, 1'b0, 4'd1); cyc(BAD, 1'b1, 1'b0, 4'd11);
    // 11 more R ops bring the 4-bit count from 5 around to 0; mem_ready toggles where ignored
    for (int i = 0; i < 11; i++) begin
      cyc(R, 1'b1, 1'b0, 4'd0);
      cyc(R, i[0], 1'b0, 4'd1);
      cyc(R, i[0], 1'b0, 4'd6);
      cyc(R, ~i[0], 1'b0, 4'd7);
    end
    // sw stalled in MEMWR, then reset for 3 cycles
    cyc(SW, 1'b1, 1'b0, 4'd0); cyc(SW, 1'b1, 1'b0, 4'd1); cyc(SW, 1'b0, 1'b0, 4'd2);
    cyc(SW, 1'b0, 1'b0, 4'd5);
    cyc(SW, 1'b1, 1'b1, 4'd0); cyc(SW, 1'b1, 1'b1, 4'd0); cyc(SW, 1'b1, 1'b1, 4'd0);
    cyc(SW, 1'b1, 1'b0, 4'd0); cyc(R, 1'b1, 1'b0, 4'd1);
    cyc(R, 1'b1, 1'b0, 4'd6); cyc(R, 1'b1, 1'b0, 4'd7); cyc(R, 1'b1, 1'b0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
